// File: rtl/mem_port_responder.sv
// Memory-side responder: arbitrates imem fetches and dmem loads/stores onto one 64-bit bmem port.
// Sub-word stores use read-modify-write. Define MEM_RESP_RR_ARB_EN for round-robin arbitration.
module mem_port_responder #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [63:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [63:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  output logic        bmem_write,
  output logic [63:0] bmem_wdata,
  input  logic        bmem_ready,
  input  logic [31:0] bmem_raddr,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  // state   | meaning
  // IDLE    | no transaction in flight; arbitrate between pending slots
  // RD_REQ  | bmem_read held until bmem_ready
  // RD_WAIT | waiting for the rvalid beat tagged with the issued address
  // WR_REQ  | merged store beat held on bmem_write until bmem_ready
  // RESP    | one-cycle resp pulse to the granted port, its slot released
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t      state;
  logic        grant_dmem;

  logic        imem_pend;
  logic [31:0] imem_addr_q;
  logic        dmem_pend;
  logic        dmem_store_q;
  logic [31:0] dmem_addr_q;
  logic [3:0]  dmem_wmask_q;
  logic [31:0] dmem_wdata_q;

  logic        imem_req;
  logic        dmem_req;
  logic        imem_clr;
  logic        dmem_clr;
  logic        grant_fire;
  logic        grant_dmem_c;
  logic [31:0] grant_addr;
  logic        beat_hit;
  logic [63:0] merged_beat;

  assign imem_req   = |imem_rmask;
  assign dmem_req   = (|dmem_rmask) || (|dmem_wmask);
  assign imem_clr   = (state == RESP) && !grant_dmem;
  assign dmem_clr   = (state == RESP) && grant_dmem;
  assign grant_fire = (state == IDLE) && (imem_pend || dmem_pend);
  assign grant_addr = grant_dmem_c ? dmem_addr_q : imem_addr_q;
  assign beat_hit   = bmem_rvalid && (bmem_raddr == bmem_addr);

  // A request arriving in the resp cycle replaces the slot being released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_pend   <= 1'b0;
      imem_addr_q <= '0;
    end else if (imem_req && (!imem_pend || imem_clr)) begin
      imem_pend   <= 1'b1;
      imem_addr_q <= imem_addr;
    end else if (imem_clr) begin
      imem_pend   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_pend    <= 1'b0;
      dmem_store_q <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wmask_q <= '0;
      dmem_wdata_q <= '0;
    end else if (dmem_req && (!dmem_pend || dmem_clr)) begin
      dmem_pend    <= 1'b1;
      dmem_store_q <= |dmem_wmask;
      dmem_addr_q  <= dmem_addr;
      dmem_wmask_q <= dmem_wmask;
      dmem_wdata_q <= dmem_wdata;
    end else if (dmem_clr) begin
      dmem_pend    <= 1'b0;
    end
  end

`ifdef MEM_RESP_RR_ARB_EN
  logic rr_ptr_imem;

  assign grant_dmem_c = dmem_pend && (!imem_pend || !rr_ptr_imem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_imem <= 1'b0;
    end else if (grant_fire) begin
      rr_ptr_imem <= grant_dmem_c;
    end
  end
`else
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign grant_dmem_c = dmem_pend && !(imem_pend && (starve_cnt == CNT_W'(STARVE_LIMIT)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_fire) begin
      if (!grant_dmem_c) begin
        starve_cnt <= '0;
      end else if (imem_pend) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`endif

  // Store bytes land in the half of the beat selected by addr[2].
  always_comb begin
    merged_beat = bmem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (dmem_wmask_q[i]) begin
        merged_beat[(int'(dmem_addr_q[2]) * 4 + i) * 8 +: 8] = dmem_wdata_q[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_dmem <= 1'b0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
      imem_resp  <= 1'b0;
      imem_rdata <= '0;
      dmem_resp  <= 1'b0;
      dmem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_fire) begin
            grant_dmem <= grant_dmem_c;
            bmem_addr  <= grant_addr & ~32'h7;
            bmem_read  <= 1'b1;
            state      <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (beat_hit) begin
            if (grant_dmem && dmem_store_q) begin
              bmem_wdata <= merged_beat;
              bmem_write <= 1'b1;
              state      <= WR_REQ;
            end else if (grant_dmem) begin
              dmem_resp  <= 1'b1;
              dmem_rdata <= bmem_rdata;
              state      <= RESP;
            end else begin
              imem_resp  <= 1'b1;
              imem_rdata <= bmem_rdata;
              state      <= RESP;
            end
          end
        end
        WR_REQ: begin
          if (bmem_ready) begin
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
            dmem_resp  <= 1'b1;
            dmem_rdata <= '0;
            state      <= RESP;
          end
        end
        RESP: begin
          imem_resp  <= 1'b0;
          imem_rdata <= '0;
          dmem_resp  <= 1'b0;
          dmem_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_responder.sv
// Scoreboard bench for mem_port_responder: directed requests push expected responses and bmem
// operations into queues; a bmem model and a resp monitor pop and compare independently.
`timescale 1ns/1ps
module tb_mem_port_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [63:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [63:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  mem_port_responder #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct { logic is_dmem; logic [63:0] data; int lat; int issue; } resp_t;
  typedef struct { logic wr; logic [31:0] addr; logic [63:0] wdata; } op_t;
  typedef struct { logic [31:0] raddr; logic [63:0] rdata; } beat_t;

  resp_t       exp_q[$];
  op_t         op_q[$];
  beat_t       beat_q[$];
  logic [63:0] mem [logic [31:0]];

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          stall_rd = 0;
  int          stall_wr = 0;
  bit          bad_beat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_resp(logic is_dmem, logic [63:0] data, int lat);
    exp_q.push_back('{is_dmem, data, lat, cyc});
  endtask

  task automatic exp_op(logic wr, logic [31:0] addr, logic [63:0] wdata);
    op_q.push_back('{wr, addr, wdata});
  endtask

  task automatic drive_none();
    imem_rmask = 4'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while ((exp_q.size() > 0 || op_q.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_cmp++;
    if (exp_q.size() > 0 || op_q.size() > 0) begin
      n_err++;
      $display("FAIL %s: timeout with %0d resp and %0d bmem ops outstanding, expected 0",
               name, exp_q.size(), op_q.size());
      exp_q.delete();
      op_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(string name);
    check({name, "_imem_resp"},  imem_resp,  0);
    check({name, "_imem_rdata"}, imem_rdata, 0);
    check({name, "_dmem_resp"},  dmem_resp,  0);
    check({name, "_dmem_rdata"}, dmem_rdata, 0);
    check({name, "_bmem_read"},  bmem_read,  0);
    check({name, "_bmem_write"}, bmem_write, 0);
    check({name, "_bmem_addr"},  bmem_addr,  0);
    check({name, "_bmem_wdata"}, bmem_wdata, 0);
  endtask

  // bmem model: decides ready at the negedge, returns read data one cycle after acceptance.
  initial begin
    beat_t       b;
    op_t         o;
    bit          stalling;
    logic [31:0] stall_addr;
    bit          stall;
    stalling    = 1'b0;
    stall_addr  = '0;
    bmem_ready  = 1'b1;
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    forever begin
      @(negedge clk);
      bmem_rvalid = 1'b0;
      if (beat_q.size() > 0) begin
        b = beat_q.pop_front();
        bmem_rvalid = 1'b1;
        bmem_raddr  = b.raddr;
        bmem_rdata  = b.rdata;
      end
      if (bmem_read || bmem_write) begin
        stall = bmem_read ? (stall_rd > 0) : (stall_wr > 0);
        if (stall) begin
          bmem_ready = 1'b0;
          if (bmem_read) stall_rd--;
          else stall_wr--;
          if (stalling) check("bmem_addr_hold", bmem_addr, stall_addr);
          stalling   = 1'b1;
          stall_addr = bmem_addr;
        end else begin
          bmem_ready = 1'b1;
          stalling   = 1'b0;
          check("bmem_rd_wr_exclusive", bmem_read && bmem_write, 0);
          if (op_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL bmem_op: unexpected op wr=%0d addr=%h, expected none", bmem_write, bmem_addr);
          end else begin
            o = op_q.pop_front();
            check("bmem_op_kind", bmem_write, o.wr);
            check("bmem_addr", bmem_addr, o.addr);
            if (o.wr) check("bmem_wdata", bmem_wdata, o.wdata);
          end
          if (bmem_write) begin
            mem[bmem_addr] = bmem_wdata;
          end else begin
            if (bad_beat) beat_q.push_back('{32'hDEAD_0000, 64'hBAD0_BAD0_BAD0_BAD0});
            beat_q.push_back('{bmem_addr, mem.exists(bmem_addr) ? mem[bmem_addr] : 64'h0});
          end
        end
      end else begin
        bmem_ready = 1'b1;
        stalling   = 1'b0;
      end
    end
  end

  // Response monitor.
  initial begin
    resp_t e;
    bit    prev_resp;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_resp || dmem_resp) begin
        check("single_resp", imem_resp && dmem_resp, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL resp: unexpected resp imem=%0d dmem=%0d, expected none", imem_resp, dmem_resp);
        end else begin
          e = exp_q.pop_front();
          check("resp_port_is_dmem", dmem_resp, e.is_dmem);
          check("resp_rdata", e.is_dmem ? dmem_rdata : imem_rdata, e.data);
          if (e.lat > 0) check("resp_latency", 64'(cyc - e.issue), 64'(e.lat));
        end
        prev_resp = 1'b1;
      end else begin
        if (prev_resp) begin
          check("imem_rdata_after_resp", imem_rdata, 0);
          check("dmem_rdata_after_resp", dmem_rdata, 0);
        end
        prev_resp = 1'b0;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    imem_addr  = '0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    drive_none();
    mem[32'h1000] = 64'h1111_2222_3333_4444;
    mem[32'h4010] = 64'h4444_0000_0000_4010;
    mem[32'h5008] = 64'h5555_6666_7777_8888;
    mem[32'h6000] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem[32'h7000] = 64'h7777_7777_7777_7777;
    for (int i = 0; i < 6; i++) mem[32'h3000 + 32'(i * 8)] = 64'hC0DE_0000_0000_0000 + 64'(i);

    repeat (2) tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // Fetch: 4-cycle latency, aligned beat.
    tick();
    exp_op(1'b0, 32'h1000, '0);
    exp_resp(1'b0, 64'h1111_2222_3333_4444, 4);
    imem_addr = 32'h1004; imem_rmask = 4'hF;
    tick();
    drive_none();
    wait_drain("fetch", 50);

    // Sub-word store into upper half: RMW, 5-cycle latency.
    tick();
    exp_op(1'b0, 32'h2000, '0);
    exp_op(1'b1, 32'h2000, 64'h0000_CCDD_0000_0000);
    exp_resp(1'b1, 64'h0, 5);
    dmem_addr = 32'h2004; dmem_wmask = 4'b0011; dmem_wdata = 32'hAABB_CCDD;
    tick();
    drive_none();
    wait_drain("store_upper", 50);

    // Fetch and load in the same cycle.
    tick();
`ifdef MEM_RESP_RR_ARB_EN
    exp_op(1'b0, 32'h1000, '0);
    exp_op(1'b0, 32'h2000, '0);
    exp_resp(1'b0, 64'h1111_2222_3333_4444, 4);
    exp_resp(1'b1, 64'h0000_CCDD_0000_0000, 0);
`else
    exp_op(1'b0, 32'h2000, '0);
    exp_op(1'b0, 32'h1000, '0);
    exp_resp(1'b1, 64'h0000_CCDD_0000_0000, 4);
    exp_resp(1'b0, 64'h1111_2222_3333_4444, 0);
`endif
    imem_addr = 32'h1000; imem_rmask = 4'hF;
    dmem_addr = 32'h2000; dmem_rmask = 4'hF;
    tick();
    drive_none();
    wait_drain("same_cycle_arb", 60);

    // Six back-to-back loads with a fetch pending.
    tick();
`ifdef MEM_RESP_RR_ARB_EN
    exp_op(1'b0, 32'h4010, '0);
    exp_resp(1'b0, 64'h4444_0000_0000_4010, 0);
    for (int i = 0; i < 6; i++) begin
      exp_op(1'b0, 32'h3000 + 32'(i * 8), '0);
      exp_resp(1'b1, 64'hC0DE_0000_0000_0000 + 64'(i), 0);
    end
`else
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        exp_op(1'b0, 32'h4010, '0);
        exp_resp(1'b0, 64'h4444_0000_0000_4010, 0);
      end
      exp_op(1'b0, 32'h3000 + 32'(i * 8), '0);
      exp_resp(1'b1, 64'hC0DE_0000_0000_0000 + 64'(i), 0);
    end
`endif
    imem_addr = 32'h4010; imem_rmask = 4'hF;
    dmem_addr = 32'h3000; dmem_rmask = 4'hF;
    tick();
    drive_none();
    for (int i = 1; i < 6; i++) begin
      int n = 0;
      while (!dmem_resp && n < 40) begin
        tick();
        n++;
      end
      if (!dmem_resp) begin
        n_cmp++;
        n_err++;
        $display("FAIL starve_loop: no dmem_resp within 40 cycles for load %0d, expected one", i - 1);
        break;
      end
      dmem_addr = 32'h3000 + 32'(i * 8); dmem_rmask = 4'hF;
      tick();
      drive_none();
    end
    wait_drain("starvation", 200);

    // Mismatched rvalid tag is ignored; read held through ready stall.
    bad_beat = 1'b1;
    stall_rd = 2;
    tick();
    exp_op(1'b0, 32'h5008, '0);
    exp_resp(1'b1, 64'h5555_6666_7777_8888, 7);
    dmem_addr = 32'h500C; dmem_rmask = 4'b0001;
    tick();
    drive_none();
    wait_drain("bad_beat", 60);
    bad_beat = 1'b0;

    // Both masks set: treated as a store into the lower half, then read back.
    tick();
    exp_op(1'b0, 32'h6000, '0);
    exp_op(1'b1, 32'h6000, 64'hFFFF_FFFF_1234_FFFF);
    exp_resp(1'b1, 64'h0, 5);
    dmem_addr = 32'h6000; dmem_rmask = 4'hF; dmem_wmask = 4'b1100; dmem_wdata = 32'h1234_5678;
    tick();
    drive_none();
    wait_drain("store_lower", 50);
    tick();
    exp_op(1'b0, 32'h6000, '0);
    exp_resp(1'b1, 64'hFFFF_FFFF_1234_FFFF, 4);
    dmem_addr = 32'h6004; dmem_rmask = 4'hF;
    tick();
    drive_none();
    wait_drain("store_readback", 50);

    // Reset while the write beat is stalled.
    stall_wr = 1000;
    tick();
    exp_op(1'b0, 32'h7000, '0);
    dmem_addr = 32'h7000; dmem_wmask = 4'hF; dmem_wdata = 32'h0BAD_F00D;
    tick();
    drive_none();
    begin
      int n = 0;
      while (!bmem_write && n < 40) begin
        tick();
        n++;
      end
      check("wr_req_reached", bmem_write, 1);
    end
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    repeat (3) tick();
    stall_wr = 0;
    beat_q.delete();
    rst = 1'b0;
    repeat (2) tick();
    exp_op(1'b0, 32'h7000, '0);
    exp_resp(1'b1, 64'h7777_7777_7777_7777, 4);
    dmem_addr = 32'h7000; dmem_rmask = 4'hF;
    tick();
    drive_none();
    wait_drain("post_reset_load", 50);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_responder.md
Name: mem_port_responder

Overview:
Memory-side responder for the core's imem and dmem request ports. It accepts fetch, load and store requests, arbitrates them onto the single 64-bit bmem interface, and returns one-cycle resp pulses with aligned 64-bit read data. Stores narrower than 64 bits are done as a read-modify-write, because bmem writes have no byte mask. Sits between ooo_cpu and the bmem/DRAM model at the top level.

Parameters:
STARVE_LIMIT, 3, consecutive dmem grants allowed while imem is pending before imem is forced (fixed-priority mode only)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
imem_addr  input  32  fetch address
imem_rmask  input  4  nonzero = fetch request
imem_rdata  output  64  8-byte-aligned beat containing imem_addr
imem_resp  output  1  one-cycle completion pulse
dmem_addr  input  32  load/store address
dmem_rmask  input  4  nonzero = load request
dmem_wmask  input  4  nonzero = store request; byte enables within the 32-bit word
dmem_wdata  input  32  store data
dmem_rdata  output  64  8-byte-aligned beat for loads; 0 on store resp
dmem_resp  output  1  one-cycle completion pulse
bmem_addr  output  32  beat address, low 3 bits always 0
bmem_read  output  1  read request, held until accepted
bmem_write  output  1  write request, held until accepted
bmem_wdata  output  64  write beat
bmem_ready  input  1  bmem accepts read/write this cycle
bmem_raddr  input  32  address tag of returned read data
bmem_rdata  input  64  read data
bmem_rvalid  input  1  read data valid

Behaviour:
- Reset (async, rst=1): all outputs 0, pending flags cleared, FSM=IDLE, starve counter=0, RR pointer=dmem. Reset mid-transaction abandons it; no resp is ever issued for it.
- Request capture: request is sampled when the mask is nonzero. The addr/mask/wdata are latched into a per-port pending slot. At most one outstanding request per port. A new request is legal in the cycle resp is high or later. A request arriving in the resp cycle is captured.
- dmem with both masks nonzero is illegal; wmask wins.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- IDLE: if any slot is pending, grant per the arbitration rule and go to RD_REQ. Store requests also start with a read.
- RD_REQ: bmem_read=1, bmem_addr={addr[31:3],3'b0}. On bmem_ready, go to RD_WAIT.
- RD_WAIT: wait for bmem_rvalid with bmem_raddr==issued address. Mismatching rvalid beats are ignored.
  - Load or fetch: latch the beat, go to RESP.
  - Store: merge dmem_wdata bytes where wmask[i]=1 into byte lane addr[2]*4+i of the beat, go to WR_REQ.
- WR_REQ: bmem_write=1, bmem_wdata=merged beat. On bmem_ready, go to RESP.
- RESP: pulse the granted port's resp for exactly one cycle with rdata (0 for stores), clear that slot, return to IDLE.
- Minimum latency, request to resp, bmem_ready=1 and rvalid the cycle after accept: load/fetch 4 cycles, store 5 cycles.
- bmem_read and bmem_write are never both 1. Outputs are held stable while waiting on bmem_ready.
- Arbitration (default, fixed): dmem before imem. The counter increments on each dmem grant while imem is pending and resets on an imem grant. When counter==STARVE_LIMIT and imem is pending, imem is granted.
- Resp outputs are registered; rdata is 0 whenever resp=0.

Optional Feature:
MEM_RESP_RR_ARB_EN: when defined, arbitration is round-robin. The pointer flips to the other port after each grant; if only one port is pending, that port is granted. STARVE_LIMIT and the counter are unused. When undefined, fixed dmem priority with the starvation limit applies.

Test Plan:
- Fetch 0x0000_1004, bmem_ready=1, rvalid next cycle with rdata 0x1111_2222_3333_4444 -> bmem_addr 0x1000; imem_resp pulses once with imem_rdata 0x1111_2222_3333_4444; imem_rdata=0 the cycle after.
- Store addr 0x2004, wmask 4'b0011, wdata 0xAABB_CCDD, beat 0 read -> bmem_wdata 0x0000_CCDD_0000_0000; dmem_resp once with dmem_rdata 0.
- Fetch and load issued in the same cycle -> load granted first; fetch resp follows. With MEM_RESP_RR_ARB_EN and pointer=imem, fetch is granted first.
- Six back-to-back loads with a fetch pending (STARVE_LIMIT=3) -> fetch granted after exactly 3 dmem grants.
- In RD_WAIT, rvalid with raddr 0xDEAD_0000 then the correct raddr -> first beat ignored, resp only after the correct beat.
- Assert rst during WR_REQ -> all outputs 0 immediately, no resp; the next load completes normally.
